// File: rtl/sha1_digest_collect.sv
// rtl/sha1_digest_collect.sv - SHA-1 final-state collector: round tracking, digest rebuild, masked compare, output queue
module sha1_digest_collect #(
  parameter int DEPTH = 2,
  parameter bit CHAIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  A,
  input  logic         a_first,
  input  logic [15:0]  tag_in,
  input  logic [159:0] target,
  input  logic [159:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [159:0] digest,
  output logic [15:0]  tag_out,
  output logic         match,
  output logic         overflow,
  output logic         desync,
  input  logic         clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] IV_A = CHAIN ? 32'h67452301 : 32'h0;
  localparam logic [31:0] IV_B = CHAIN ? 32'hefcdab89 : 32'h0;
  localparam logic [31:0] IV_C = CHAIN ? 32'h98badcfe : 32'h0;
  localparam logic [31:0] IV_D = CHAIN ? 32'h10325476 : 32'h0;
  localparam logic [31:0] IV_E = CHAIN ? 32'hc3d2e1f0 : 32'h0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [6:0]    rnd_q, rnd_d;
  logic [15:0]   tag_q, tag_d;
  logic [31:0]   s76_q, s77_q, s78_q, s79_q, s80_q;
  logic          done, desync_set;
  logic          add_v_q;
  logic [15:0]   add_tag_q;
  logic          h_v_q;
  logic [159:0]  h_q, h_d;
  logic [15:0]   h_tag_q;
  logic          overflow_q, overflow_d, desync_q, desync_d;
  logic [AW:0]   wr_q, rd_q;
  logic [159:0]  mem_dig   [DEPTH];
  logic [15:0]   mem_tag   [DEPTH];
  logic          mem_match [DEPTH];
  logic          empty, full, pop, push, push_ok, drop, match_d;

  // rnd_q is the round index of the word on A; the a_first cycle itself is round 0.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    tag_d      = tag_q;
    done       = 1'b0;
    desync_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_first) begin
          state_d = RUN;
          rnd_d   = 7'd1;
          tag_d   = tag_in;
        end
      end
      RUN: begin
        if (rnd_q == 7'd79) begin
          done    = 1'b1;
          state_d = a_first ? RUN : IDLE;
          rnd_d   = a_first ? 7'd1 : 7'd0;
          if (a_first) tag_d = tag_in;
        end else if (a_first) begin
          desync_set = 1'b1;
          rnd_d      = 7'd1;
          tag_d      = tag_in;
        end else begin
          rnd_d = rnd_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // B..E of the final state are earlier A words, with C..E rotated left by 30.
  assign h_d = {IV_A + s80_q,
                IV_B + s79_q,
                IV_C + {s78_q[1:0], s78_q[31:2]},
                IV_D + {s77_q[1:0], s77_q[31:2]},
                IV_E + {s76_q[1:0], s76_q[31:2]}};

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && out_ready;
  assign push    = h_v_q;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign match_d = (((h_q ^ target) & mask) == '0);

  always_comb begin
    overflow_d = clear ? 1'b0 : overflow_q;
    desync_d   = clear ? 1'b0 : desync_q;
    if (drop)       overflow_d = 1'b1;
    if (desync_set) desync_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_q      <= 7'd0;
      tag_q      <= 16'd0;
      s76_q      <= 32'd0;
      s77_q      <= 32'd0;
      s78_q      <= 32'd0;
      s79_q      <= 32'd0;
      s80_q      <= 32'd0;
      add_v_q    <= 1'b0;
      add_tag_q  <= 16'd0;
      h_v_q      <= 1'b0;
      h_q        <= 160'd0;
      h_tag_q    <= 16'd0;
      overflow_q <= 1'b0;
      desync_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      tag_q   <= tag_d;
      if (state_q == RUN) begin
        case (rnd_q)
          7'd75:   s76_q <= A;
          7'd76:   s77_q <= A;
          7'd77:   s78_q <= A;
          7'd78:   s79_q <= A;
          7'd79:   s80_q <= A;
          default: ;
        endcase
      end
      add_v_q <= done;
      if (done) add_tag_q <= tag_q;
      h_v_q <= add_v_q;
      if (add_v_q) begin
        h_q     <= h_d;
        h_tag_q <= add_tag_q;
      end
      overflow_q <= overflow_d;
      desync_q   <= desync_d;
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop)     rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // When full, a simultaneous pop frees the very slot being overwritten.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_dig[wr_q[AW-1:0]]   <= h_q;
      mem_tag[wr_q[AW-1:0]]   <= h_tag_q;
      mem_match[wr_q[AW-1:0]] <= match_d;
    end
  end

  assign out_valid = !empty;
  assign digest    = out_valid ? mem_dig[rd_q[AW-1:0]]   : 160'd0;
  assign tag_out   = out_valid ? mem_tag[rd_q[AW-1:0]]   : 16'd0;
  assign match     = out_valid ? mem_match[rd_q[AW-1:0]] : 1'b0;
  assign overflow  = overflow_q;
  assign desync    = desync_q;

endmodule

// File: tb/tb_sha1_digest_collect.sv
// tb/tb_sha1_digest_collect.sv - self-checking bench for sha1_digest_collect with a SHA-1 reference model
module tb_sha1_digest_collect;

  localparam logic [159:0] IV      = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  A;
  logic         a_first;
  logic [15:0]  tag_in;
  logic [159:0] target, mask;
  logic         out_ready, clear;
  logic         out_valid, match, overflow, desync;
  logic [159:0] digest;
  logic [15:0]  tag_out;
  logic         r_valid, r_match, r_ovf, r_desync;
  logic [159:0] r_digest;
  logic [15:0]  r_tag;

  sha1_digest_collect #(.DEPTH(2), .CHAIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .a_first(a_first), .tag_in(tag_in),
    .target(target), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .digest(digest), .tag_out(tag_out), .match(match), .overflow(overflow),
    .desync(desync), .clear(clear));

  sha1_digest_collect #(.DEPTH(2), .CHAIN(1'b0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .A(A), .a_first(a_first), .tag_in(tag_in),
    .target(target), .mask(mask), .out_valid(r_valid), .out_ready(out_ready),
    .digest(r_digest), .tag_out(r_tag), .match(r_match), .overflow(r_ovf),
    .desync(r_desync), .clear(clear));

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] target;
    logic [159:0] mask;
    logic [15:0]  tag;
    logic         exp_match;
  } vec_t;

  typedef struct {
    logic [159:0] dig;
    logic [15:0]  tag;
    logic         m;
  } ent_t;

  int           errors = 0;
  int           checks = 0;
  logic [31:0]  astream [80];
  logic [159:0] exp_dig, exp_raw;
  bit           sb_en = 1'b0;
  ent_t         sbq [$];
  vec_t         tbl [5];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [159:0] rand160();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [159:0] sub_iv(input logic [159:0] d);
    logic [159:0] iv;
    iv = IV;
    return {d[159:128] - iv[159:128], d[127:96] - iv[127:96], d[95:64] - iv[95:64],
            d[63:32] - iv[63:32], d[31:0] - iv[31:0]};
  endfunction

  // Standard SHA-1 compression: records the A word after each round and the final state.
  task automatic gen_block(input logic [511:0] blk);
    logic [31:0]  w [80];
    logic [31:0]  a, b, c, d, e, f, k, tmp;
    logic [159:0] iv;
    iv = IV;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, b, c, d, e} = iv;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
      astream[t] = a;
    end
    exp_raw = {a, b, c, d, e};
    exp_dig = {a + iv[159:128], b + iv[127:96], c + iv[95:64], d + iv[63:32], e + iv[31:0]};
  endtask

  task automatic gen_rand();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    gen_block(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sb_en) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got entry tag %h expected no entry", tag_out);
        end else begin
          ent_t e;
          e = sbq.pop_front();
          chk("sb_digest", digest, e.dig);
          chk("sb_tag", tag_out, e.tag);
          chk("sb_match", match, e.m);
        end
      end
    end
  endtask

  task automatic drive_rounds(input int from, input int to, input logic [15:0] tag);
    for (int t = from; t <= to; t++) begin
      A       = astream[t];
      a_first = (t == 0);
      tag_in  = tag;
      tick();
    end
    A       = $urandom;
    a_first = 1'b0;
    tag_in  = 16'($urandom);
  endtask

  // After the rnd 79 cycle: nothing visible in t+1 and t+2, head valid in t+3.
  task automatic expect_entry(input string name, input logic [159:0] dig, input logic [15:0] tag);
    chk({name, "_early1"}, out_valid, 1'b0);
    tick();
    chk({name, "_early2"}, out_valid, 1'b0);
    tick();
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_digest"}, digest, dig);
    chk({name, "_tag"}, tag_out, tag);
  endtask

  initial begin
    logic [159:0] d1, d2, dq, dr, dz;
    logic         seen;

    tbl[0] = '{target: ABC_DIG,             mask: '1,                   tag: 16'h0001, exp_match: 1'b1};
    tbl[1] = '{target: ABC_DIG ^ 160'h1,    mask: '1,                   tag: 16'h0002, exp_match: 1'b0};
    tbl[2] = '{target: ABC_DIG ^ 160'h1,    mask: ~160'h1,              tag: 16'h0003, exp_match: 1'b1};
    tbl[3] = '{target: ~ABC_DIG,            mask: 160'h0,               tag: 16'hbeef, exp_match: 1'b1};
    tbl[4] = '{target: ABC_DIG ^ {1'b1, 159'h0}, mask: '1,              tag: 16'hffff, exp_match: 1'b0};

    rst_n = 1'b0; A = 32'h0; a_first = 1'b0; tag_in = 16'h0;
    target = 160'h0; mask = 160'h0; out_ready = 1'b0; clear = 1'b0;
    tick();
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_digest", digest, 160'h0);
    chk("rst_tag", tag_out, 16'h0);
    chk("rst_match", match, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_desync", desync, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      gen_block(ABC_BLK);
      target    = tbl[i].target;
      mask      = tbl[i].mask;
      out_ready = 1'b1;
      drive_rounds(0, 79, tbl[i].tag);
      expect_entry("abc", ABC_DIG, tbl[i].tag);
      chk("abc_match", match, tbl[i].exp_match);
      chk("abc_raw_valid", r_valid, 1'b1);
      chk("abc_raw_digest", r_digest, sub_iv(ABC_DIG));
      tick();
      chk("abc_popped", out_valid, 1'b0);
    end

    out_ready = 1'b0;
    mask = 160'h0;
    gen_rand(); drive_rounds(0, 79, 16'h0101); d1 = exp_dig;
    gen_rand(); drive_rounds(0, 79, 16'h0202); d2 = exp_dig;
    gen_rand(); drive_rounds(0, 79, 16'h0303);
    gen_rand();
    drive_rounds(0, 0, 16'h0404);
    chk("ovf_before_third", overflow, 1'b0);
    drive_rounds(1, 1, 16'h0404);
    chk("ovf_after_third", overflow, 1'b1);
    drive_rounds(2, 79, 16'h0404);
    tick(); tick(); tick();
    chk("ovf_head_valid", out_valid, 1'b1);
    chk("ovf_head_digest", digest, d1);
    chk("ovf_head_tag", tag_out, 16'h0101);
    chk("ovf_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("ovf_second_digest", digest, d2);
    chk("ovf_second_tag", tag_out, 16'h0202);
    tick();
    chk("ovf_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    gen_rand(); drive_rounds(0, 79, 16'h0a01);
    gen_rand(); drive_rounds(0, 79, 16'h0a02); dq = exp_dig;
    gen_rand(); drive_rounds(0, 79, 16'h0a03); dr = exp_dig;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_no_overflow", overflow, 1'b0);
    chk("pp_head", digest, dq);
    tick();
    chk("pp_head_hold", digest, dq);
    chk("pp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("pp_tail", digest, dr);
    chk("pp_tail_tag", tag_out, 16'h0a03);
    tick();
    chk("pp_empty", out_valid, 1'b0);

    gen_rand();
    drive_rounds(0, 39, 16'h0aaa);
    gen_rand();
    drive_rounds(0, 0, 16'h0bbb);
    chk("desync_set", desync, 1'b1);
    drive_rounds(1, 79, 16'h0bbb);
    expect_entry("restart", exp_dig, 16'h0bbb);
    tick();
    chk("restart_only_entry", out_valid, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("desync_cleared", desync, 1'b0);

    gen_rand();
    drive_rounds(0, 9, 16'h0c01);
    gen_rand();
    clear = 1'b1;
    drive_rounds(0, 0, 16'h0c02);
    clear = 1'b0;
    chk("desync_set_wins", desync, 1'b1);
    drive_rounds(1, 50, 16'h0c02);

    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_desync", desync, 1'b0);
    chk("mid_rst_digest", digest, 160'h0);
    chk("mid_rst_raw_flags", {r_valid, r_match, r_ovf, r_desync, r_tag}, 20'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 51; t <= 79; t++) begin
      A = astream[t];
      tick();
      seen |= out_valid;
    end
    for (int i = 0; i < 10; i++) begin
      A = $urandom;
      tick();
      seen |= out_valid;
    end
    chk("no_entry_after_reset", seen, 1'b0);
    gen_rand();
    dz = exp_dig;
    drive_rounds(0, 79, 16'h0d0d);
    expect_entry("post_reset", dz, 16'h0d0d);
    tick();
    chk("post_reset_empty", out_valid, 1'b0);

    sb_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      ent_t e;
      logic [15:0] tg;
      tg = 16'($urandom);
      gen_rand();
      drive_rounds(0, 9, tg);
      mask = rand160();
      if ($urandom_range(0, 1) == 1) target = exp_dig ^ (rand160() & ~mask);
      else                          target = rand160();
      drive_rounds(10, 79, tg);
      e.dig = exp_dig;
      e.tag = tg;
      e.m   = (((exp_dig ^ target) & mask) == 160'h0);
      sbq.push_back(e);
      for (int g = $urandom_range(0, 5); g > 0; g--) tick();
    end
    for (int i = 0; i < 30; i++) tick();
    sb_en = 1'b0;
    chk("sb_all_delivered", 160'(sbq.size()), 160'h0);
    chk("sb_no_overflow", overflow, 1'b0);
    chk("sb_no_desync", desync, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
